transposed_fir_param: RTL and testbench

Parametrised transposed-form FIR filter, the next generation of the fixed 18-bit transposedFilter.
- Width, tap count and output scaling are parameters.
- Coefficients are run-time loadable through a write port.
- Output is saturated.
- Sits in the sample datapath: samples arrive qualified by DataNd_i and leave qualified by DataValid_o.

---
 rtl/transposed_fir_param.sv | 99 +++++++++
 tb/tb_transposed_fir_param.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/transposed_fir_param.sv
// Transposed-form FIR with run-time loadable coefficients, arithmetic-shift scaling and saturated output.
// Define TRANSPOSED_FIR_ROUND_EN for round-half-up scaling; the default build floors.
module transposed_fir_param #(
    parameter int DATA_W = 18,
    parameter int COEF_W = 18,
    parameter int TAPS   = 8,
    parameter int SHIFT  = COEF_W - 1
) (
    input  logic                     Clk_i,
    input  logic                     Rstn_i,
    input  logic signed [DATA_W-1:0] Data_i,
    input  logic                     DataNd_i,
    input  logic                     Flush_i,
    input  logic                     CoefWe_i,
    input  logic [$clog2(TAPS)-1:0]  CoefAddr_i,
    input  logic signed [COEF_W-1:0] CoefData_i,
    output logic signed [DATA_W-1:0] Data_o,
    output logic                     DataValid_o
);
    localparam int AW    = $clog2(TAPS);
    localparam int P_W   = DATA_W + COEF_W;
    localparam int ACC_W = P_W + $clog2(TAPS);
    localparam int SW    = ACC_W + 1;

    localparam logic [COEF_W-1:0] C_RST0 = {1'b0, {(COEF_W-1){1'b1}}};
    localparam logic signed [SW-1:0] S_MAX = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SW-1:0] S_MIN = {{(SW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`ifdef TRANSPOSED_FIR_ROUND_EN
    localparam logic signed [SW-1:0] RND =
        (SHIFT > 0) ? (SW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
`else
    localparam logic signed [SW-1:0] RND = '0;
`endif

    logic signed [DATA_W-1:0]    x_r;
    logic [1:0]                  vld_pipe;
    logic [TAPS-1:0][COEF_W-1:0] coef;
    logic [TAPS-1:0][P_W-1:0]    prod;
    // acc[TAPS] is a permanent zero so every tap shares one update expression
    logic [TAPS:0][ACC_W-1:0]    acc;
    logic signed [SW-1:0]        rnd_sum;
    logic signed [SW-1:0]        scaled;
    logic [DATA_W-1:0]           sat_val;

    always_ff @(posedge Clk_i or negedge Rstn_i) begin
        if (!Rstn_i) begin
            x_r      <= '0;
            vld_pipe <= '0;
        end else if (Flush_i) begin
            x_r      <= '0;
            vld_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], DataNd_i};
            if (DataNd_i) x_r <= Data_i;
        end
    end

    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        assign prod[k] = P_W'(x_r) * P_W'($signed(coef[k]));
    end

    // Coefficient writes land on the same edge as a chain update, so that update sees the old value
    always_ff @(posedge Clk_i or negedge Rstn_i) begin
        if (!Rstn_i) begin
            acc <= '0;
            for (int k = 0; k < TAPS; k++) coef[k] <= (k == 0) ? C_RST0 : '0;
        end else begin
            for (int k = 0; k < TAPS; k++)
                if (CoefWe_i && CoefAddr_i == AW'(k)) coef[k] <= CoefData_i;
            if (Flush_i)
                acc <= '0;
            else if (vld_pipe[0])
                for (int k = 0; k < TAPS; k++)
                    acc[k] <= ACC_W'($signed(prod[k])) + acc[k+1];
        end
    end

    assign rnd_sum = SW'($signed(acc[0])) + RND;
    assign scaled  = rnd_sum >>> SHIFT;

    always_comb begin
        sat_val = scaled[DATA_W-1:0];
        if (scaled > S_MAX)      sat_val = S_MAX[DATA_W-1:0];
        else if (scaled < S_MIN) sat_val = S_MIN[DATA_W-1:0];
    end

    always_ff @(posedge Clk_i or negedge Rstn_i) begin
        if (!Rstn_i) begin
            Data_o      <= '0;
            DataValid_o <= 1'b0;
        end else if (Flush_i) begin
            DataValid_o <= 1'b0;
        end else begin
            DataValid_o <= vld_pipe[1];
            if (vld_pipe[1]) Data_o <= sat_val;
        end
    end

endmodule

// File: tb/tb_transposed_fir_param.sv
// Bench for transposed_fir_param (default parameters): vector tables plus a scoreboard with latency check.
module tb_transposed_fir_param;
    localparam int T = 8;

    logic        Clk_i = 1'b0;
    logic        Rstn_i = 1'b1;
    logic [17:0] Data_i = '0;
    logic        DataNd_i = 1'b0;
    logic        Flush_i = 1'b0;
    logic        CoefWe_i = 1'b0;
    logic [2:0]  CoefAddr_i = '0;
    logic [17:0] CoefData_i = '0;
    logic [17:0] Data_o;
    logic        DataValid_o;

    transposed_fir_param dut (
        .Clk_i(Clk_i), .Rstn_i(Rstn_i), .Data_i(Data_i), .DataNd_i(DataNd_i),
        .Flush_i(Flush_i), .CoefWe_i(CoefWe_i), .CoefAddr_i(CoefAddr_i),
        .CoefData_i(CoefData_i), .Data_o(Data_o), .DataValid_o(DataValid_o)
    );

    always #5 Clk_i = ~Clk_i;

    typedef struct { logic [17:0] din; logic [17:0] exp; } vec_t;
    typedef struct { logic [17:0] exp; int due; } sb_t;

    sb_t    sbq[$];
    sb_t    e;
    int     n_tests = 0;
    int     n_fail = 0;
    int     cyc = 0;
    longint cm[T];
    longint hist[T];

`ifdef TRANSPOSED_FIR_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    always @(posedge Clk_i) cyc <= cyc + 1;

    task automatic chk(string nm, logic [17:0] act, logic [17:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard: each DataValid_o pops one expectation and must arrive exactly on its due cycle
    always @(negedge Clk_i) begin
        if (sbq.size() > 0 && sbq[0].due < cyc) begin
            n_tests++; n_fail++;
            $display("FAIL missing_valid: got no valid at cycle %0d want data %h", sbq[0].due, sbq[0].exp);
            void'(sbq.pop_front());
        end
        if (DataValid_o === 1'b1) begin
            if (sbq.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_valid: got valid data %h at cycle %0d want no valid", Data_o, cyc);
            end else begin
                e = sbq.pop_front();
                chk("data", Data_o, e.exp);
                n_tests++;
                if (e.due != cyc) begin
                    n_fail++;
                    $display("FAIL latency: got valid at cycle %0d want cycle %0d", cyc, e.due);
                end
            end
        end
    end

    function automatic logic [17:0] model_y();
        longint s = 0;
        for (int k = 0; k < T; k++) s += cm[k] * hist[k];
        if (RND) s += 65536;
        s = s >>> 17;
        if (s > 131071) s = 131071;
        else if (s < -131072) s = -131072;
        return s[17:0];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < T; k++) begin
            cm[k] = (k == 0) ? 131071 : 0;
            hist[k] = 0;
        end
    endtask

    task automatic tick();
        @(posedge Clk_i); #1;
        DataNd_i = 1'b0; Flush_i = 1'b0; CoefWe_i = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) tick();
    endtask

    task automatic put(logic [17:0] d, logic [17:0] x);
        tick();
        DataNd_i = 1'b1; Data_i = d;
        for (int k = T - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = longint'($signed(d));
        sbq.push_back('{x, cyc + 3});
    endtask

    task automatic put_m(logic [17:0] d);
        for (int k = T - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = longint'($signed(d));
        tick();
        DataNd_i = 1'b1; Data_i = d;
        sbq.push_back('{model_y(), cyc + 3});
    endtask

    task automatic wr(int a, logic [17:0] d);
        tick();
        CoefWe_i = 1'b1; CoefAddr_i = 3'(a); CoefData_i = d;
        cm[a] = longint'($signed(d));
    endtask

    task automatic flush();
        tick();
        Flush_i = 1'b1;
        for (int k = 0; k < T; k++) hist[k] = 0;
    endtask

    initial begin
        vec_t        t1[10];
        vec_t        t3[4];
        logic [31:0] r;
        logic [17:0] imp_y;

        for (int i = 0; i < 10; i++) begin
            t1[i].din = (i == 0) ? 18'h00400 : 18'h0;
            t1[i].exp = (i < 8) ? 18'(8 * (i + 1)) : 18'h0;
        end
        t3[0] = '{18'h00001, RND ? 18'h00001 : 18'h00000};
        t3[1] = '{18'h3FFFF, RND ? 18'h00000 : 18'h3FFFF};
        t3[2] = '{18'h00003, RND ? 18'h00002 : 18'h00001};
        t3[3] = '{18'h3FFFD, RND ? 18'h3FFFF : 18'h3FFFE};
        imp_y = RND ? 18'h10000 : 18'h0FFFF;

        // Reset state
        model_reset();
        #1 Rstn_i = 1'b0;
        #11;
        chk("reset_data", Data_o, 18'h0);
        chk("reset_valid", {17'h0, DataValid_o}, 18'h0);
        @(negedge Clk_i) Rstn_i = 1'b1;

        // Impulse response, continuous then every 3rd cycle
        for (int k = 0; k < T; k++) wr(k, 18'((k + 1) * 18'h400));
        idle(2);
        for (int i = 0; i < 10; i++) put(t1[i].din, t1[i].exp);
        idle(3);
        for (int i = 0; i < 10; i++) begin
            put(t1[i].din, t1[i].exp);
            idle(2);
        end
        idle(3);

        // Saturation at both rails
        for (int k = 0; k < T; k++) wr(k, 18'h1FFFF);
        flush();
        for (int i = 0; i < 10; i++) put(18'h1FFFF, (i == 0) ? 18'h1FFFE : 18'h1FFFF);
        idle(3);
        flush();
        for (int i = 0; i < 10; i++) put(18'h20000, (i == 0) ? 18'h20001 : 18'h20000);
        idle(3);

        // Scaling rounding with a half-scale single tap
        wr(0, 18'h10000);
        for (int k = 1; k < T; k++) wr(k, 18'h0);
        flush();
        for (int i = 0; i < 4; i++) put(t3[i].din, t3[i].exp);
        idle(3);

        // Random coefficients and data with random gaps against a direct-form model
        for (int k = 0; k < T; k++) begin
            r = $urandom;
            wr(k, {{4{r[13]}}, r[13:0]});
        end
        flush();
        for (int i = 0; i < 40; i++) begin
            put_m(18'($urandom));
            idle($urandom_range(0, 2));
        end
        idle(4);

        // Coefficient write coincident with an update edge, then flush mid-response
        tick(); Rstn_i = 1'b0; #2; Rstn_i = 1'b1;
        model_reset();
        put(18'h10000, imp_y);
        idle(3);
        put(18'h10000, imp_y);
        wr(0, 18'h0);
        idle(3);
        put(18'h10000, 18'h0);
        idle(3);
        wr(3, 18'h1FFFF);
        idle(2);
        put(18'h10000, 18'h0);
        put(18'h0, 18'h0);
        idle(2);
        tick(); Flush_i = 1'b1; DataNd_i = 1'b1; Data_i = 18'h10000;
        for (int i = 0; i < 6; i++) put(18'h0, 18'h0);
        idle(4);

        // Asynchronous reset between edges while outputs are in flight
        for (int k = 0; k < T; k++) wr(k, 18'((k + 1) * 18'h400));
        idle(2);
        for (int i = 0; i < 4; i++) put(t1[i].din, t1[i].exp);
        @(posedge Clk_i); #2;
        chk("pre_reset_valid", {17'h0, DataValid_o}, 18'h1);
        Rstn_i = 1'b0; DataNd_i = 1'b0;
        sbq.delete();
        #1;
        chk("async_reset_data", Data_o, 18'h0);
        chk("async_reset_valid", {17'h0, DataValid_o}, 18'h0);
        #10 Rstn_i = 1'b1;
        model_reset();
        idle(3);
        put(18'h10000, imp_y);
        for (int i = 0; i < 3; i++) put(18'h0, 18'h0);

        for (int i = 0; i < 30 && sbq.size() > 0; i++) tick();
        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending outputs want 0", sbq.size());
        end
        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
